// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image on boot_rx and writes it word-by-word
// to system memory while holding the CPU in reset.
module uart_boot_loader #(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         TIMEOUT_CLKS = 1200000,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_rx,
    input  logic        bus_busy,
    output logic        cpu_hold,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic        bus_we,
    output logic        load_done,
    output logic        load_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_SYNC, ADDR, COUNT, DATA, WRITE, CHECK, DONE_ST, ERROR} state_t;

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_state_next;
    logic [CW-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    rx_shift, rx_shift_next;
    logic          byte_valid, byte_valid_next;
    logic          frame_err, frame_err_next;

    state_t        state, state_next;
    logic [1:0]    byte_idx, byte_idx_next;
    logic [31:0]   word_idx, word_idx_next;
    logic [31:0]   word_count, word_count_next;
    logic [7:0]    checksum, checksum_next;
    logic [TW-1:0] timer, timer_next;
    logic [31:0]   address_next, write_data_next;
    logic          cpu_hold_next, load_err_next;
    logic          timed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= boot_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state   <= rx_state_next;
            rx_cnt     <= rx_cnt_next;
            bit_idx    <= bit_idx_next;
            rx_shift   <= rx_shift_next;
            byte_valid <= byte_valid_next;
            frame_err  <= frame_err_next;
        end
    end

    // The start bit is re-checked at mid-bit so short glitches never start a byte.
    always_comb begin
        rx_state_next   = rx_state;
        rx_cnt_next     = rx_cnt;
        bit_idx_next    = bit_idx;
        rx_shift_next   = rx_shift;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    bit_idx_next  = '0;
                    rx_state_next = rx_sync ? RX_IDLE : RX_BITS;
                end else begin
                    rx_cnt_next = rx_cnt + CW'(1);
                end
            end
            RX_BITS: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    bit_idx_next  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) rx_state_next = RX_STOP;
                end else begin
                    rx_cnt_next = rx_cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_state_next   = RX_IDLE;
                    byte_valid_next = rx_sync;
                    frame_err_next  = !rx_sync;
                end else begin
                    rx_cnt_next = rx_cnt + CW'(1);
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign bus_we    = (state == WRITE);
    assign load_done = (state == DONE_ST);
    assign timed     = (state == ADDR) || (state == COUNT) || (state == DATA) || (state == CHECK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= WAIT_SYNC;
            byte_idx       <= '0;
            word_idx       <= '0;
            word_count     <= '0;
            checksum       <= '0;
            timer          <= '0;
            bus_address    <= '0;
            bus_write_data <= '0;
            cpu_hold       <= 1'b1;
            load_err       <= 1'b0;
        end else begin
            state          <= state_next;
            byte_idx       <= byte_idx_next;
            word_idx       <= word_idx_next;
            word_count     <= word_count_next;
            checksum       <= checksum_next;
            timer          <= timer_next;
            bus_address    <= address_next;
            bus_write_data <= write_data_next;
            cpu_hold       <= cpu_hold_next;
            load_err       <= load_err_next;
        end
    end

    // Multi-byte fields arrive little-endian, so each byte shifts in from the top.
    always_comb begin
        state_next      = state;
        byte_idx_next   = byte_idx;
        word_idx_next   = word_idx;
        word_count_next = word_count;
        checksum_next   = checksum;
        address_next    = bus_address;
        write_data_next = bus_write_data;
        cpu_hold_next   = cpu_hold;
        load_err_next   = load_err;
        timer_next      = '0;
        if (timed && !byte_valid) timer_next = timer + TW'(1);
        case (state)
            WAIT_SYNC: begin
                if (byte_valid && rx_shift == SYNC_BYTE) begin
                    state_next    = ADDR;
                    cpu_hold_next = 1'b1;
                    load_err_next = 1'b0;
                    checksum_next = '0;
                    byte_idx_next = '0;
                    word_idx_next = '0;
                end
            end
            ADDR: begin
                if (byte_valid) begin
                    address_next  = {rx_shift, bus_address[31:8]};
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        address_next[1:0] = 2'b00;
                        state_next        = COUNT;
                    end
                end
            end
            COUNT: begin
                if (byte_valid) begin
                    word_count_next = {rx_shift, word_count[31:8]};
                    byte_idx_next   = byte_idx + 2'd1;
                    if (byte_idx == 2'd3)
                        state_next = (word_count_next != 32'd0) ? DATA : CHECK;
                end
            end
            DATA: begin
                if (byte_valid) begin
                    write_data_next = {rx_shift, bus_write_data[31:8]};
                    checksum_next   = checksum + rx_shift;
                    byte_idx_next   = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) state_next = WRITE;
                end
            end
            WRITE: begin
                if (byte_valid || frame_err) begin
                    state_next    = ERROR;
                    load_err_next = 1'b1;
                end else if (!bus_busy) begin
                    address_next  = bus_address + 32'd4;
                    word_idx_next = word_idx + 32'd1;
                    state_next    = (word_idx_next == word_count) ? CHECK : DATA;
                end
            end
            CHECK: begin
                if (byte_valid) begin
                    if (rx_shift == checksum) begin
                        state_next    = DONE_ST;
                        cpu_hold_next = 1'b0;
                    end else begin
                        state_next    = ERROR;
                        load_err_next = 1'b1;
                    end
                end
            end
            DONE_ST: state_next = WAIT_SYNC;
            ERROR:   state_next = WAIT_SYNC;
            default: state_next = WAIT_SYNC;
        endcase
        // Framing errors and inter-byte silence abort any in-progress frame.
        if (timed && (frame_err || (!byte_valid && timer == TIMEOUT_LAST))) begin
            state_next    = ERROR;
            load_err_next = 1'b1;
        end
    end

endmodule
